// File: rtl/nav_cmd_arbiter_if.sv
// Request/command bundle between the pulse sources, nav_cmd_arbiter and the menu/game consumer.
// cmd_valid/cmd_ready: a command transfers on any clk_100mhz edge where both are high; cmd_valid never depends on cmd_ready.
interface nav_cmd_arbiter_if;
  logic       btn_up_pulse;
  logic       btn_down_pulse;
  logic       btn_sel_pulse;
  logic       voice_hi_pulse;
  logic       voice_lo_pulse;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_src;
  logic [1:0] holdoff_active;
  logic [7:0] drop_count;

  modport master (
    output btn_up_pulse, btn_down_pulse, btn_sel_pulse, voice_hi_pulse, voice_lo_pulse, cmd_ready,
    input  cmd_valid, cmd_code, cmd_src, holdoff_active, drop_count
  );

  modport slave (
    input  btn_up_pulse, btn_down_pulse, btn_sel_pulse, voice_hi_pulse, voice_lo_pulse, cmd_ready,
    output cmd_valid, cmd_code, cmd_src, holdoff_active, drop_count
  );
endinterface

// File: rtl/nav_cmd_arbiter.sv
// Merges button and voice navigation pulses into one ordered command FIFO with per-source holdoff.
// Define NAV_ARB_VOICE_EN to enable the VOICE requester; otherwise only buttons are arbitrated.
module nav_cmd_arbiter #(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 10_000_000
) (
  input  logic              clk_100mhz,
  input  logic              reset,
  nav_cmd_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  localparam logic [1:0] CODE_UP   = 2'b01;
  localparam logic [1:0] CODE_DOWN = 2'b10;
  localparam logic [1:0] CODE_SEL  = 2'b11;

  // FIFO entry layout: {code[1:0], src}
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drop_count;
  logic          r_rr_last_tie;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_push;
  logic [2:0]    w_push_data;
  logic          w_grant_b;
  logic          w_grant_v;
  logic          w_tie;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = !w_empty && bus.cmd_ready;
  assign w_push_ok = !w_full || w_pop;

  // BTN requester
  logic          r_b_pend_vld;
  logic [1:0]    r_b_pend_code;
  logic [HW-1:0] r_b_hold;
  logic          w_b_any;
  logic          w_b_blocked;
  logic          w_b_conflict;
  logic          w_b_drop;
  logic          w_b_cap;
  logic [1:0]    w_b_code;

  assign w_b_any      = bus.btn_up_pulse | bus.btn_down_pulse | bus.btn_sel_pulse;
  assign w_b_blocked  = r_b_pend_vld || (r_b_hold != '0);
  assign w_b_conflict = bus.btn_up_pulse && bus.btn_down_pulse && !bus.btn_sel_pulse;
  assign w_b_drop     = w_b_any && (w_b_blocked || w_b_conflict);
  assign w_b_cap      = w_b_any && !w_b_blocked && !w_b_conflict;
  assign w_b_code     = bus.btn_sel_pulse ? CODE_SEL : (bus.btn_up_pulse ? CODE_UP : CODE_DOWN);

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_b_pend_vld  <= 1'b0;
      r_b_pend_code <= 2'b00;
      r_b_hold      <= '0;
    end else begin
      if (w_grant_b) begin
        r_b_pend_vld <= 1'b0;
      end else if (w_b_cap) begin
        r_b_pend_vld  <= 1'b1;
        r_b_pend_code <= w_b_code;
      end
      if (w_grant_b)
        r_b_hold <= HOLD_LOAD;
      else if (r_b_hold != '0)
        r_b_hold <= r_b_hold - 1'b1;
    end
  end

  // VOICE requester
  logic       w_v_pend_vld;
  logic [1:0] w_v_pend_code;
  logic       w_v_hold_nz;
  logic       w_v_drop;
`ifdef NAV_ARB_VOICE_EN
  logic          r_v_pend_vld;
  logic [1:0]    r_v_pend_code;
  logic [HW-1:0] r_v_hold;
  logic          w_v_any;
  logic          w_v_blocked;
  logic          w_v_conflict;
  logic          w_v_cap;

  assign w_v_any      = bus.voice_hi_pulse | bus.voice_lo_pulse;
  assign w_v_blocked  = r_v_pend_vld || (r_v_hold != '0);
  assign w_v_conflict = bus.voice_hi_pulse && bus.voice_lo_pulse;
  assign w_v_drop     = w_v_any && (w_v_blocked || w_v_conflict);
  assign w_v_cap      = w_v_any && !w_v_blocked && !w_v_conflict;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_v_pend_vld  <= 1'b0;
      r_v_pend_code <= 2'b00;
      r_v_hold      <= '0;
    end else begin
      if (w_grant_v) begin
        r_v_pend_vld <= 1'b0;
      end else if (w_v_cap) begin
        r_v_pend_vld  <= 1'b1;
        r_v_pend_code <= bus.voice_hi_pulse ? CODE_UP : CODE_DOWN;
      end
      if (w_grant_v)
        r_v_hold <= HOLD_LOAD;
      else if (r_v_hold != '0)
        r_v_hold <= r_v_hold - 1'b1;
    end
  end

  assign w_v_pend_vld  = r_v_pend_vld;
  assign w_v_pend_code = r_v_pend_code;
  assign w_v_hold_nz   = (r_v_hold != '0);
`else
  logic w_unused_voice;
  assign w_unused_voice = bus.voice_hi_pulse | bus.voice_lo_pulse;
  assign w_v_pend_vld   = 1'b0;
  assign w_v_pend_code  = 2'b00;
  assign w_v_hold_nz    = 1'b0;
  assign w_v_drop       = 1'b0;
`endif

  // The round-robin pointer only moves on contention: a tie goes to the source that lost the last tie.
  always_comb begin
    w_grant_b = 1'b0;
    w_grant_v = 1'b0;
    if (w_push_ok) begin
      if (r_b_pend_vld && w_v_pend_vld) begin
        if (r_rr_last_tie) w_grant_b = 1'b1;
        else               w_grant_v = 1'b1;
      end else if (r_b_pend_vld) begin
        w_grant_b = 1'b1;
      end else if (w_v_pend_vld) begin
        w_grant_v = 1'b1;
      end
    end
  end

  assign w_tie       = r_b_pend_vld && w_v_pend_vld && w_push_ok;
  assign w_push      = w_grant_b || w_grant_v;
  assign w_push_data = w_grant_b ? {r_b_pend_code, 1'b0} : {w_v_pend_code, 1'b1};

  logic [8:0] w_drop_sum;
  assign w_drop_sum = {1'b0, r_drop_count} + {8'd0, w_b_drop} + {8'd0, w_v_drop};

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_drop_count  <= 8'd0;
      r_rr_last_tie <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_tie) r_rr_last_tie <= w_grant_v;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign bus.cmd_valid      = !w_empty;
  assign bus.cmd_code       = w_empty ? 2'b00 : r_mem[r_rd_ptr][2:1];
  assign bus.cmd_src        = w_empty ? 1'b0  : r_mem[r_rd_ptr][0];
  assign bus.holdoff_active = {w_v_hold_nz, (r_b_hold != '0)};
  assign bus.drop_count     = r_drop_count;
endmodule

// File: tb/tb_nav_cmd_arbiter.sv
// Bench for nav_cmd_arbiter: constant vector table, directed corner sequences and a random run
// checked every cycle against a queue-based model of the arbitration rules.
module tb_nav_cmd_arbiter;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic clk_100mhz = 1'b0;
  logic reset;

  nav_cmd_arbiter_if bus ();

  nav_cmd_arbiter #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct packed {
    logic up, down, sel, hi, lo, rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic       valid;
    logic [1:0] code;
    logic       src;
    logic [1:0] hold;
    logic [7:0] drop;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // model state: one pending slot and holdoff count per source (0 BTN, 1 VOICE)
  logic [2:0] exp_q[$];
  bit         m_pend_v[2];
  logic [1:0] m_pend_c[2];
  int         m_hold[2];
  int         m_last_tie;
  int         m_drop;

  // last sampled DUT outputs and consumer-side record of accepted commands
  logic       o_valid, o_src;
  logic [1:0] o_code, o_hold;
  logic [7:0] o_drop;
  logic [2:0] obs_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(bit up, bit down, bit sel, bit hi, bit lo, bit rdy);
    in_t r;
    r.up = up; r.down = down; r.sel = sel; r.hi = hi; r.lo = lo; r.rdy = rdy;
    return r;
  endfunction

  function automatic vec_t mk_vec(in_t in, bit v, logic [1:0] c, bit s, logic [1:0] h, logic [7:0] d);
    vec_t r;
    r.in = in; r.valid = v; r.code = c; r.src = s; r.hold = h; r.drop = d;
    return r;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      m_pend_v[s] = 1'b0;
      m_pend_c[s] = 2'b00;
      m_hold[s]   = 0;
    end
    m_last_tie = 1;
    m_drop     = 0;
  endfunction

  function automatic void model_step(in_t in);
    bit         pop, push_ok;
    int         g;
    bit         any[2], bad[2], drop[2];
    logic [1:0] code[2];
    g       = -1;
    pop     = (exp_q.size() > 0) && in.rdy;
    push_ok = (exp_q.size() < DEPTH) || pop;
    if (push_ok) begin
      if (m_pend_v[0] && m_pend_v[1]) begin
        g = 1 - m_last_tie;
        m_last_tie = g;
      end else if (m_pend_v[0]) g = 0;
      else if (m_pend_v[1]) g = 1;
    end
    any[0]  = in.up || in.down || in.sel;
    bad[0]  = in.up && in.down && !in.sel;
    code[0] = in.sel ? 2'd3 : (in.up ? 2'd1 : 2'd2);
`ifdef NAV_ARB_VOICE_EN
    any[1]  = in.hi || in.lo;
    bad[1]  = in.hi && in.lo;
    code[1] = in.hi ? 2'd1 : 2'd2;
`else
    any[1]  = 1'b0;
    bad[1]  = 1'b0;
    code[1] = 2'd0;
`endif
    for (int s = 0; s < 2; s++)
      drop[s] = any[s] && (m_pend_v[s] || (m_hold[s] != 0) || bad[s]);
    if (pop) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back({m_pend_c[g], 1'(g)});
      m_pend_v[g] = 1'b0;
    end
    for (int s = 0; s < 2; s++) begin
      if (s == g) m_hold[s] = HOLD;
      else if (m_hold[s] > 0) m_hold[s] = m_hold[s] - 1;
      if (any[s] && !drop[s]) begin
        m_pend_v[s] = 1'b1;
        m_pend_c[s] = code[s];
      end
    end
    m_drop = m_drop + int'(drop[0]) + int'(drop[1]);
    if (m_drop > 255) m_drop = 255;
  endfunction

  task automatic apply(in_t in);
    bus.btn_up_pulse   = in.up;
    bus.btn_down_pulse = in.down;
    bus.btn_sel_pulse  = in.sel;
    bus.voice_hi_pulse = in.hi;
    bus.voice_lo_pulse = in.lo;
    bus.cmd_ready      = in.rdy;
  endtask

  // Entered just after a rising edge: drive, sample and check at the falling edge, advance the model.
  task automatic cycle(in_t in);
    apply(in);
    @(negedge clk_100mhz);
    o_valid = bus.cmd_valid;
    o_code  = bus.cmd_code;
    o_src   = bus.cmd_src;
    o_hold  = bus.holdoff_active;
    o_drop  = bus.drop_count;
    if (o_valid === 1'b1 && in.rdy) obs_q.push_back({o_code, o_src});
    chk("model_valid", o_valid, (exp_q.size() > 0));
    chk("model_code", o_code, (exp_q.size() > 0) ? exp_q[0][2:1] : 2'b00);
    chk("model_src", o_src, (exp_q.size() > 0) ? exp_q[0][0] : 1'b0);
    chk("model_hold", o_hold, {(m_hold[1] != 0), (m_hold[0] != 0)});
    chk("model_drop", o_drop, m_drop);
    @(posedge clk_100mhz);
    model_step(in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(mk_in(0, 0, 0, 0, 0, 0));
    @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cycle(mk_in(0, 0, 0, 0, 0, rdy));
  endtask

  vec_t       tab[12];
  in_t        stim[6];
  logic [2:0] exp_list[6];
  int         n_stim;

  initial begin
    model_reset();
    do_reset();

    // single BTN UP, latency, holdoff window and a drop during holdoff
    tab[0]  = mk_vec(mk_in(1, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b00, 8'd0);
    tab[1]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b00, 8'd0);
    tab[2]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 1, 2'b01, 0, 2'b01, 8'd0);
    tab[3]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd0);
    tab[4]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd0);
    tab[5]  = mk_vec(mk_in(1, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd0);
    tab[6]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd1);
    tab[7]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd1);
    tab[8]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd1);
    tab[9]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b01, 8'd1);
    tab[10] = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b00, 8'd1);
    tab[11] = mk_vec(mk_in(0, 0, 0, 0, 0, 1), 0, 2'b00, 0, 2'b00, 8'd1);
    for (int i = 0; i < 12; i++) begin
      cycle(tab[i].in);
      chk($sformatf("tab%0d_valid", i), o_valid, tab[i].valid);
      chk($sformatf("tab%0d_code", i), o_code, tab[i].code);
      chk($sformatf("tab%0d_src", i), o_src, tab[i].src);
      chk($sformatf("tab%0d_hold", i), o_hold, tab[i].hold);
      chk($sformatf("tab%0d_drop", i), o_drop, tab[i].drop);
    end

`ifdef NAV_ARB_VOICE_EN
    // tie: BTN wins first, VOICE wins the repeat
    do_reset();
    cycle(mk_in(0, 0, 1, 0, 1, 1));
    idle(1, 1);
    idle(1, 1);
    chk("tie1_first", {o_valid, o_code, o_src}, 4'b1110);
    idle(1, 1);
    chk("tie1_second", {o_valid, o_code, o_src}, 4'b1101);
    idle(12, 1);
    cycle(mk_in(0, 0, 1, 0, 1, 1));
    idle(2, 1);
    chk("tie2_first", {o_valid, o_code, o_src}, 4'b1101);
    idle(1, 1);
    chk("tie2_second", {o_valid, o_code, o_src}, 4'b1110);
    idle(4, 1);
`else
    // voice ignored when the requester is compiled out
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cycle(mk_in(0, 0, 0, 1, 1'($urandom_range(0, 1)), 1));
      chk("novoice_valid", o_valid, 1'b0);
    end
    chk("novoice_drop", o_drop, 8'd0);
    chk("novoice_hold", o_hold, 2'b00);
`endif

    // full FIFO: pendings held, further pulse from a held source drops, then in-order drain
    do_reset();
`ifdef NAV_ARB_VOICE_EN
    n_stim = 6;
    stim[0] = mk_in(1, 0, 0, 0, 0, 0); exp_list[0] = 3'b010;
    stim[1] = mk_in(0, 0, 0, 1, 0, 0); exp_list[1] = 3'b011;
    stim[2] = mk_in(0, 1, 0, 0, 0, 0); exp_list[2] = 3'b100;
    stim[3] = mk_in(0, 0, 0, 0, 1, 0); exp_list[3] = 3'b101;
    stim[4] = mk_in(0, 0, 1, 0, 0, 0); exp_list[4] = 3'b110;
    stim[5] = mk_in(0, 0, 0, 1, 0, 0); exp_list[5] = 3'b011;
`else
    n_stim = 5;
    stim[0] = mk_in(1, 0, 0, 0, 0, 0); exp_list[0] = 3'b010;
    stim[1] = mk_in(0, 1, 0, 0, 0, 0); exp_list[1] = 3'b100;
    stim[2] = mk_in(0, 0, 1, 0, 0, 0); exp_list[2] = 3'b110;
    stim[3] = mk_in(1, 0, 0, 0, 0, 0); exp_list[3] = 3'b010;
    stim[4] = mk_in(0, 1, 0, 0, 0, 0); exp_list[4] = 3'b100;
    stim[5] = mk_in(0, 0, 0, 0, 0, 0); exp_list[5] = 3'b000;
`endif
    for (int t = 0; t < 12 * n_stim + 6; t++) begin
      if (t % 12 == 0 && t / 12 < n_stim) cycle(stim[t / 12]);
      else if (t == 12 * n_stim) cycle(mk_in(1, 0, 0, 0, 0, 0));
      else cycle(mk_in(0, 0, 0, 0, 0, 0));
    end
    chk("full_valid", o_valid, 1'b1);
    chk("full_drop", o_drop, 8'd1);
    obs_q.delete();
    idle(20, 1);
    chk("drain_count", obs_q.size(), n_stim);
    for (int i = 0; i < n_stim && i < obs_q.size(); i++)
      chk($sformatf("drain_order%0d", i), obs_q[i], exp_list[i]);

    // up+down together is a drop with no command; then saturation
    do_reset();
    cycle(mk_in(1, 1, 0, 0, 0, 1));
    idle(1, 1);
    chk("updown_drop", o_drop, 8'd1);
    idle(2, 1);
    chk("updown_valid", o_valid, 1'b0);
    for (int i = 0; i < 300; i++) cycle(mk_in(1, 1, 0, 1, 1, 1));
    idle(1, 1);
    chk("drop_sat", o_drop, 8'd255);

    // reset with entries queued and holdoff running
    do_reset();
    cycle(mk_in(1, 1, 0, 0, 0, 0));
    idle(1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(mk_in(k == 0, k == 1, k == 2, 0, 0, 0));
      idle(9, 0);
    end
    cycle(mk_in(1, 0, 0, 0, 0, 0));
    idle(2, 0);
    chk("prereset_valid", o_valid, 1'b1);
    chk("prereset_hold", o_hold[0], 1'b1);
    do_reset();
    idle(1, 1);
    chk("postreset_valid", o_valid, 1'b0);
    chk("postreset_drop", o_drop, 8'd0);
    chk("postreset_hold", o_hold, 2'b00);

    // random traffic with varying consumer throughput
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 100; i++)
        cycle(mk_in($urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 99) < rdy_pct));
    end
    idle(20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
